// File: rtl/clk_phase_sched_pkg.sv
// Shared types for the multi-channel divided-clock scheduler.
// Config fields are CFG_W bits wide; the top-level W should match.
package clk_phase_sched_pkg;

    localparam int CFG_W          = 8;
    localparam int CFG_BITS       = 3 * CFG_W;
    localparam int RST_PERIOD_DEF = 2;
    localparam int RST_HIGH_DEF   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } cfg_t;

    function automatic cfg_t make_rst_cfg(input int p, input int h);
        cfg_t c;
        c.period = CFG_W'(p);
        c.high   = CFG_W'(h);
        c.phase  = '0;
        return c;
    endfunction

    localparam cfg_t DEF_CFG = make_rst_cfg(RST_PERIOD_DEF, RST_HIGH_DEF);

endpackage

// File: rtl/clk_phase_sched_channel.sv
// One divided-clock channel: active/shadow config, phase delay,
// period counter and registered waveform/rise outputs.
module clk_phase_channel
    import clk_phase_sched_pkg::*;
#(
    parameter int RST_PERIOD = RST_PERIOD_DEF,
    parameter int RST_HIGH   = RST_HIGH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    input  logic                go_i,
    input  logic                halt_i,
    input  logic                wr_i,
    input  logic [CFG_BITS-1:0] wcfg_i,
    output logic                pend_o,
    output logic                div_o,
    output logic                rise_o
);

    localparam cfg_t RST_CFG = make_rst_cfg(RST_PERIOD, RST_HIGH);

    cfg_t             act_q;
    cfg_t             shd_q;
    cfg_t             wcfg;
    cfg_t             eff;
    cfg_t             nxt;
    logic             pend_q;
    logic             div_q;
    logic             rise_q;
    logic [CFG_W-1:0] ph_q;
    logic [CFG_W-1:0] cnt_q;
    logic [CFG_W-1:0] cnt_inc;
    logic             in_delay;
    logic             at_wrap;
    logic             boundary;

    assign wcfg     = cfg_t'(wcfg_i);
    // config seen by a start; a same-cycle write wins
    assign eff      = wr_i ? wcfg : act_q;
    // config that takes over at the next period boundary
    assign nxt      = pend_q ? shd_q : act_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign in_delay = ph_q != '0;
    assign at_wrap  = cnt_q == (act_q.period - 1'b1);
    // boundary: last delay cycle, or last cycle of a period
    assign boundary = in_delay ? (ph_q == CFG_W'(1)) : at_wrap;

    // config shadowing, phase/period counting and waveform generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= RST_CFG;
            shd_q  <= RST_CFG;
            pend_q <= 1'b0;
            ph_q   <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            rise_q <= 1'b0;
        end else if (halt_i) begin
            act_q  <= wr_i ? wcfg : nxt;
            pend_q <= 1'b0;
            ph_q   <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            rise_q <= 1'b0;
        end else if (run_i) begin
            if (wr_i) begin
                shd_q  <= wcfg;
                pend_q <= 1'b1;
            end
            if (boundary) begin
                cnt_q  <= '0;
                div_q  <= nxt.high != '0;
                rise_q <= nxt.high != '0;
                if (pend_q) begin
                    act_q  <= shd_q;
                    pend_q <= 1'b0;
                end
            end else if (in_delay) begin
                div_q  <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_inc;
                div_q  <= cnt_inc < act_q.high;
                rise_q <= 1'b0;
            end
            if (in_delay) begin
                ph_q <= ph_q - 1'b1;
            end
        end else begin
            if (wr_i) begin
                act_q <= wcfg;
            end
            if (go_i) begin
                ph_q   <= eff.phase;
                cnt_q  <= '0;
                div_q  <= (eff.phase == '0) && (eff.high != '0);
                rise_q <= (eff.phase == '0) && (eff.high != '0);
            end else begin
                div_q  <= 1'b0;
                rise_q <= 1'b0;
            end
        end
    end

    assign pend_o = pend_q;
    assign div_o  = div_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/clk_phase_scheduler.sv
// Multi-channel phase-aligned divided-clock generator: run/stop FSM,
// config decode and legality check, per-channel generators.
module clk_phase_scheduler
    import clk_phase_sched_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int W          = CFG_W,
    parameter int RST_PERIOD = RST_PERIOD_DEF,
    parameter int RST_HIGH   = RST_HIGH_DEF,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_period,
    input  logic [W-1:0]   cfg_high,
    input  logic [W-1:0]   cfg_phase,
    output logic           cfg_err,
    output logic           running,
    output logic [NCH-1:0] div_out,
    output logic [NCH-1:0] rise
);

    logic [1:0]     rsync_q;
    logic           rst_int_n;
    state_t         state_q;
    logic           running_q;
    logic           err_q;
    logic           run_st;
    logic           go;
    logic           halt;
    logic           legal;
    logic           busy;
    logic           wr_en;
    logic [NCH-1:0] pend_vec;
    cfg_t           wcfg;

    // reset asserts asynchronously, releases two clocks later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsync_q <= 2'b00;
        end else begin
            rsync_q <= {rsync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rsync_q[1];

    assign run_st = state_q == RUN;
    // stop beats a same-cycle start in IDLE
    assign go     = !run_st && start && !stop;
    assign halt   = run_st && stop;

    assign legal = (cfg_period != '0) && (cfg_high <= cfg_period);
    // one outstanding runtime update per channel
    assign busy  = run_st && pend_vec[cfg_ch];
    // illegal writes are always taken (and dropped)
    assign cfg_ready = !busy || !legal;
    assign wr_en     = cfg_valid && legal && !busy;

    assign wcfg = '{
        period: CFG_W'(cfg_period),
        high:   CFG_W'(cfg_high),
        phase:  CFG_W'(cfg_phase)
    };

    // run/stop sequencing with registered running flag
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // error pulse the cycle after an illegal write
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cfg_valid && !legal;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_phase_channel #(
            .RST_PERIOD(RST_PERIOD),
            .RST_HIGH  (RST_HIGH)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_int_n),
            .run_i (run_st),
            .go_i  (go),
            .halt_i(halt),
            .wr_i  (wr_en && (cfg_ch == CHW'(i))),
            .wcfg_i(wcfg),
            .pend_o(pend_vec[i]),
            .div_o (div_out[i]),
            .rise_o(rise[i])
        );
    end

    assign cfg_err = err_q;
    assign running = running_q;

endmodule

// File: tb/tb_clk_phase_scheduler.sv
// Bench for clk_phase_scheduler: arithmetic reference model,
// per-cycle compare, directed literal checks, random stimulus.
module tb_clk_phase_scheduler;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [7:0]     cfg_period = '0;
    logic [7:0]     cfg_high = '0;
    logic [7:0]     cfg_phase = '0;
    logic           cfg_err;
    logic           running;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] rise;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    clk_phase_scheduler #(.NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .running   (running),
        .div_out   (div_out),
        .rise      (rise)
    );

    // reference model: waveform is a function of run cycle k,
    // the start phase and the cycle the current period config began
    int aP[NCH], aH[NCH], aPh[NCH];
    int sP[NCH], sH[NCH], sPh[NCH];
    int seg[NCH], rph[NCH];
    bit pend[NCH];
    bit mrun;
    int k;
    int rs;
    logic [NCH-1:0] e_div, e_rise;
    logic e_run, e_err;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endfunction

    function automatic void model_outputs();
        e_run = mrun;
        for (int c = 0; c < NCH; c++) begin
            int m;
            e_div[c] = 1'b0;
            e_rise[c] = 1'b0;
            if (mrun && k >= rph[c]) begin
                m = (k - seg[c]) % aP[c];
                e_div[c] = m < aH[c];
                e_rise[c] = (m == 0) && (aH[c] > 0);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            aP[c] = 2; aH[c] = 1; aPh[c] = 0;
            sP[c] = 2; sH[c] = 1; sPh[c] = 0;
            seg[c] = 0; rph[c] = 0; pend[c] = 1'b0;
        end
        mrun = 1'b0;
        k = 0;
        rs = 0;
        e_err = 1'b0;
        model_outputs();
    endfunction

    function automatic void model_step();
        bit legal, busy, wr;
        int wc;
        wc = int'(cfg_ch);
        legal = (cfg_period != 0) && (cfg_high <= cfg_period);
        busy = mrun && pend[wc];
        wr = cfg_valid && legal && !busy;
        e_err = cfg_valid && !legal;
        if (!mrun) begin
            if (wr) begin
                aP[wc] = cfg_period; aH[wc] = cfg_high; aPh[wc] = cfg_phase;
            end
            if (start && !stop) begin
                mrun = 1'b1;
                k = 0;
                for (int c = 0; c < NCH; c++) begin
                    rph[c] = aPh[c];
                    seg[c] = aPh[c];
                end
            end
        end else if (stop) begin
            for (int c = 0; c < NCH; c++) begin
                if (pend[c]) begin
                    aP[c] = sP[c]; aH[c] = sH[c]; aPh[c] = sPh[c];
                end
                pend[c] = 1'b0;
            end
            if (wr) begin
                aP[wc] = cfg_period; aH[wc] = cfg_high; aPh[wc] = cfg_phase;
            end
            mrun = 1'b0;
        end else begin
            k++;
            for (int c = 0; c < NCH; c++) begin
                bit first, wrp;
                first = k == rph[c];
                wrp = (k > rph[c]) && (((k - seg[c]) % aP[c]) == 0);
                if (first || wrp) begin
                    seg[c] = k;
                    if (pend[c]) begin
                        aP[c] = sP[c]; aH[c] = sH[c]; aPh[c] = sPh[c];
                        pend[c] = 1'b0;
                    end
                end
            end
            if (wr) begin
                sP[wc] = cfg_period; sH[wc] = cfg_high; sPh[wc] = cfg_phase;
                pend[wc] = 1'b1;
            end
        end
        model_outputs();
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (rs < 2) rs++;
            else model_step();
        end
    end

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit lg;
                logic e_rdy;
                lg = (cfg_period != 0) && (cfg_high <= cfg_period);
                e_rdy = !(mrun && pend[int'(cfg_ch)]) || !lg;
                chk("div_out", div_out, e_div);
                chk("rise", rise, e_rise);
                chk("running", running, e_run);
                chk("cfg_err", cfg_err, e_err);
                chk("cfg_ready", cfg_ready, e_rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(int ch, int p, int h, int ph);
        cfg_valid = 1'b1;
        cfg_ch = 2'(ch);
        cfg_period = 8'(p);
        cfg_high = 8'(h);
        cfg_phase = 8'(ph);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    logic [0:9]  t2d0 = 10'b0110011001;
    logic [0:9]  t2d1 = 10'b0111100001;
    logic [0:10] t3d0 = 11'b11001110001;
    logic [0:5]  t5d2 = 6'b001001;
    logic [0:9]  t6d3 = 10'b0011111111;
    logic [0:9]  t6r3 = 10'b0010010010;

    initial begin
        repeat (3) tick();
        chk_en = 1'b1;
        #1 rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_div", div_out, 0);
        tick();

        // two channels, phase 1, coinciding rises
        wr(0, 4, 2, 1);
        wr(1, 8, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 10; kk++) begin
            @(negedge clk);
            chk("t2_div0", div_out[0], t2d0[kk]);
            chk("t2_div1", div_out[1], t2d1[kk]);
            chk("t2_rise0", rise[0], (kk == 1 || kk == 5 || kk == 9));
            chk("t2_rise1", rise[1], (kk == 1 || kk == 9));
            tick();
        end

        // asynchronous reset mid-run
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_run", running, 0);
        chk("t1_async_div", div_out, 0);
        chk("t1_async_rise", rise, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            @(negedge clk);
            chk("t1_div0", div_out[0], (kk % 2 == 0));
            chk("t1_rise0", rise[0], (kk % 2 == 0));
            if (kk == 0) chk("t1_running", running, 1);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("t1_stopped", running, 0);
        tick();

        // runtime reconfiguration lands on the wrap
        wr(0, 4, 2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 11; kk++) begin
            cfg_valid = 1'b0;
            if (kk == 2) begin
                cfg_valid = 1'b1; cfg_ch = 2'd0;
                cfg_period = 8'd6; cfg_high = 8'd3; cfg_phase = 8'd0;
            end else if (kk == 3) begin
                cfg_valid = 1'b1; cfg_ch = 2'd0;
                cfg_period = 8'd5; cfg_high = 8'd1; cfg_phase = 8'd0;
            end
            @(negedge clk);
            chk("t3_div0", div_out[0], t3d0[kk]);
            if (kk == 2) chk("t3_ready_k2", cfg_ready, 1);
            if (kk == 3) chk("t3_ready_k3", cfg_ready, 0);
            tick();
        end
        cfg_valid = 1'b0;
        stop_run();

        // illegal writes
        cfg_valid = 1'b1; cfg_ch = 2'd0;
        cfg_period = 8'd0; cfg_high = 8'd0; cfg_phase = 8'd0;
        @(negedge clk);
        chk("t4_ready_p0", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("t4_err_p0", cfg_err, 1);
        tick();
        @(negedge clk);
        chk("t4_err_clr", cfg_err, 0);
        wr(0, 4, 5, 0);
        @(negedge clk);
        chk("t4_err_h", cfg_err, 1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            @(negedge clk);
            chk("t4_keep_div0", div_out[0], (kk < 3));
            tick();
        end
        stop_run();

        // start+stop together, stop with a pending shadow
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("t5_ss_running", running, 0);
        tick();
        wr(2, 20, 5, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 7; kk++) begin
            cfg_valid = 1'b0;
            stop = 1'b0;
            if (kk == 1) begin
                cfg_valid = 1'b1; cfg_ch = 2'd2;
                cfg_period = 8'd3; cfg_high = 8'd1; cfg_phase = 8'd2;
            end else if (kk == 3) begin
                cfg_valid = 1'b1; cfg_ch = 2'd2;
                cfg_period = 8'd4; cfg_high = 8'd2; cfg_phase = 8'd0;
            end
            if (kk == 6) stop = 1'b1;
            @(negedge clk);
            if (kk == 3) chk("t5_ready_pend", cfg_ready, 0);
            tick();
        end
        cfg_valid = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("t5_stop_run", running, 0);
        chk("t5_stop_div", div_out, 0);
        chk("t5_stop_rise", rise, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 6; kk++) begin
            @(negedge clk);
            chk("t5_div2", div_out[2], t5d2[kk]);
            tick();
        end
        stop_run();

        // H=0 and H=P channels
        wr(2, 5, 0, 0);
        wr(3, 3, 3, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int kk = 0; kk < 10; kk++) begin
            @(negedge clk);
            chk("t6_div2", div_out[2], 0);
            chk("t6_rise2", rise[2], 0);
            chk("t6_div3", div_out[3], t6d3[kk]);
            chk("t6_rise3", rise[3], t6r3[kk]);
            tick();
        end
        stop_run();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int p;
            if (mrun) begin
                start = ($urandom % 50) == 0;
                stop = ($urandom % 40) == 0;
            end else begin
                start = ($urandom % 6) == 0;
                stop = ($urandom % 30) == 0;
            end
            cfg_valid = ($urandom % 3) == 0;
            cfg_ch = 2'($urandom % 4);
            p = (($urandom % 20) == 0) ? 0 : int'($urandom_range(1, 9));
            cfg_period = 8'(p);
            if (($urandom % 20) == 0) cfg_high = 8'(p + 1);
            else cfg_high = 8'($urandom_range(0, p));
            cfg_phase = 8'($urandom_range(0, 5));
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_phase_scheduler.md
Name: clk_phase_scheduler

Overview:
- Programmable multi-channel divided-clock generator for testbench and on-chip timing use.
- Produces NCH phase-aligned divided waveforms from one base clock. Each channel has its own period, high time and start offset, all counted in base-clock cycles.
- Starts all channels from a common reference instant.
- Sequences run/stop and shadows runtime reconfiguration so that changes land only on a channel's period boundary, never mid-cycle.

Parameters:
- NCH, 4, number of output channels (1..16)
- W, 8, width of the period, high-time and phase fields
- RST_PERIOD, 2, active period of every channel after reset
- RST_HIGH, 1, active high time of every channel after reset

Ports:
- clk  input  1  base clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begin generation (honoured only in IDLE)
- stop  input  1  single-cycle pulse; halt generation (honoured only in RUN)
- cfg_valid  input  1  config write request
- cfg_ready  output  1  config write accepted when high together with cfg_valid
- cfg_ch  input  $clog2(NCH)  target channel
- cfg_period  input  W  period in cycles, legal range 1..2^W-1
- cfg_high  input  W  high time in cycles, legal range 0..cfg_period
- cfg_phase  input  W  delay in cycles from start before the first period
- cfg_err  output  1  one-cycle pulse, the cycle after an illegal write (period=0 or high>period); the write is dropped
- running  output  1  high while in RUN
- div_out  output  NCH  divided waveform per channel; registered
- rise  output  NCH  one-cycle pulse aligned with each div_out period start; registered

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE; div_out=0, rise=0, running=0, cfg_ready=1, cfg_err=0. Every channel's active config = RST_PERIOD / RST_HIGH / phase 0. All pending bits cleared.
- FSM IDLE:
  - In IDLE, div_out=0 and rise=0.
  - A legal write goes directly into the channel's active registers.
  - start -> RUN.
  - A legal write in the same cycle as start is applied first and is in effect for the first RUN cycle.
- FSM RUN:
  - RUN cycle k: k=0 is the first cycle after start is sampled. running=1 from k=0.
  - Channel i, with active (P, H, Ph): div_out[i]=1 iff k>=Ph and ((k-Ph) mod P) < H.
  - rise[i]=1 iff k>=Ph, (k-Ph) mod P == 0, and H>0.
  - H=0 gives a constant 0. H=P gives a constant 1 once k>=Ph, and rise still pulses every period.
  - Implementation per channel: a phase down-counter loaded with Ph at start, then a period counter 0..P-1 that wraps.
  - start while in RUN is ignored.
- FSM RUN -> IDLE:
  - stop -> IDLE the next cycle. div_out, rise and running are 0 from that cycle.
  - Pending shadows are copied to active on the transition.
  - stop and start in the same cycle: stop wins.
- Runtime reconfiguration (RUN):
  - A legal write loads the channel's shadow registers and sets its pending bit.
  - At the channel's next wrap (counter = P-1 -> 0), shadow -> active and pending is cleared. The new P/H take effect from the cycle after that wrap. Phase is not re-applied; the new phase is used only at the next start.
  - If the write coincides with the wrap cycle, the update lands at the following wrap.
  - A write during a channel's phase-delay window is applied when the delay expires, before the first period.
- cfg_ready=0 iff in RUN and channel cfg_ch already has pending=1, so there is at most one outstanding update per channel. Otherwise cfg_ready=1.
- Illegal writes are always accepted (cfg_ready=1), dropped, and produce the cfg_err pulse.
- Channels are independent. Simultaneous wraps or updates on different channels do not interact.

Decomposition:
- Package clk_phase_sched_pkg holds:
  - FSM state enum {IDLE, RUN}
  - channel config struct {period, high, phase} of width W
  - default-config constant built from RST_PERIOD / RST_HIGH
- Sub-module clk_phase_channel holds one channel's active and shadow registers, pending bit, phase counter, period counter, div_out and rise. It is instantiated NCH times with a generate loop.
- The top level holds the FSM, the config decode and legality check, and cfg_ready/cfg_err.

Test Plan:
1. Reset mid-RUN, with rst_n low for 1 cycle at an arbitrary edge -> div_out, rise and running go to 0 immediately (async). After release, ch0 runs at P=2, H=1 on a new start.
2. In IDLE, ch0 = P4 H2 Ph1 and ch1 = P8 H4 Ph1, then start -> from k=0:
   - ch0 div_out = 0,1,1,0,0,1,1,0,...
   - ch1 div_out = 0,1,1,1,1,0,0,0,0,1,...
   - rise at k=1,5,9 (ch0) and k=1,9 (ch1); the two channels' rising edges coincide.
3. RUN with ch0 at P4 H2; write P6 H3 at k=2 -> waveform unchanged through k=3, then 1,1,1,0,0,0 from k=4. A second write to ch0 before k=4 sees cfg_ready=0.
4. Write cfg_period=0, and separately high=5 with period=4 -> each write is accepted, cfg_err pulses one cycle later, and the active config is unchanged.
5. start and stop in the same cycle in IDLE -> running stays 0. In RUN, stop at k=6 -> div_out=0 and running=0 from the next cycle, and pending shadows are visible at the next start.
6. ch2 with H=0, ch3 with H=P=3 -> ch2 is constant 0 with no rise. ch3 is constant 1 after its phase, with rise every 3 cycles.
